// File: rtl/instr_decoder.sv
// instr_decoder: byte-serial 24-bit instruction decoder that issues LDA/INC/DEC to an accumulator.
// Define DEC_ERR_CNT_EN to add the saturating err_cnt output.
module instr_decoder #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        dec_rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        acc_ready,
  output logic [23:0] opcode,
  output logic        op_rdy,
  output logic        acc_en,
  output logic [7:0]  dec_data,
  output logic        dec_err
`ifdef DEC_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] B1    = 3'd1;
  localparam logic [2:0] B2    = 3'd2;
  localparam logic [2:0] OPND  = 3'd3;
  localparam logic [2:0] ISSUE = 3'd4;

  localparam logic [23:0] OP_LDA = 24'h888800;
  localparam logic [23:0] OP_INC = 24'h888801;
  localparam logic [23:0] OP_DEC = 24'h888802;

  logic [2:0]  state;
  logic [15:0] hi_bytes;
  logic [7:0]  idle_cnt;
  logic        xfer;
  logic        expire;
  logic [23:0] full_op;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign xfer    = byte_valid & byte_ready;
  // Expiry fires on the edge that ends the TIMEOUT_CYCLES-th idle cycle; a transfer wins.
  assign expire  = (TIMEOUT_CYCLES != 8'd0) && (idle_cnt == TIMEOUT_CYCLES - 8'd1);
  assign full_op = {hi_bytes, byte_in};

  always_ff @(posedge clk or negedge dec_rst_n) begin
    if (!dec_rst_n) begin
      state      <= IDLE;
      hi_bytes   <= 16'h0;
      idle_cnt   <= 8'h0;
      byte_ready <= 1'b0;
      opcode     <= 24'h0;
      op_rdy     <= 1'b0;
      acc_en     <= 1'b0;
      dec_data   <= 8'h0;
      dec_err    <= 1'b0;
    end else begin
      // Outputs are registered images of the next state.
      byte_ready <= 1'b1;
      op_rdy     <= 1'b0;
      acc_en     <= 1'b0;
      dec_err    <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= 8'h0;
          if (xfer) begin
            hi_bytes[15:8] <= byte_in;
            state          <= B1;
          end
        end
        B1, B2, OPND: begin
          if (xfer) begin
            idle_cnt <= 8'h0;
            if (state == B1) begin
              hi_bytes[7:0] <= byte_in;
              state         <= B2;
            end else if (state == B2) begin
              if (full_op == OP_LDA) begin
                state <= OPND;
              end else if (full_op == OP_INC || full_op == OP_DEC) begin
                opcode     <= full_op;
                dec_data   <= 8'h00;
                byte_ready <= 1'b0;
                op_rdy     <= 1'b1;
                acc_en     <= 1'b1;
                state      <= ISSUE;
              end else begin
                dec_err <= 1'b1;
                state   <= IDLE;
              end
            end else begin
              // Only LDA reaches OPND, so the issued opcode is known.
              opcode     <= OP_LDA;
              dec_data   <= byte_in;
              byte_ready <= 1'b0;
              op_rdy     <= 1'b1;
              acc_en     <= 1'b1;
              state      <= ISSUE;
            end
          end else if (expire) begin
            dec_err  <= 1'b1;
            idle_cnt <= 8'h0;
            state    <= IDLE;
          end else begin
            idle_cnt <= sat_inc(idle_cnt);
          end
        end
        ISSUE: begin
          if (acc_ready) begin
            state <= IDLE;
          end else begin
            byte_ready <= 1'b0;
            op_rdy     <= 1'b1;
            acc_en     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge dec_rst_n) begin
    if (!dec_rst_n) begin
      err_cnt <= 8'h0;
    end else if (dec_err) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd255: idle cycles allowed mid-instruction before abort; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port dec_rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port byte_in, input, 8: instruction stream byte.
REQ-005 SHALL have port byte_valid, input, 1: byte_in valid.
REQ-006 SHALL have port byte_ready, output, 1: decoder can accept a byte.
REQ-007 SHALL have port acc_ready, input, 1: the accumulator takes the issued instruction this cycle.
REQ-008 SHALL have port opcode, output, 24: decoded opcode to the accumulator.
REQ-009 SHALL have port op_rdy, output, 1: opcode valid.
REQ-010 SHALL have port acc_en, output, 1: accumulator enable.
REQ-011 SHALL have port dec_data, output, 8: operand to the accumulator data input.
REQ-012 SHALL have port dec_err, output, 1: one-cycle error pulse.

Function
REQ-013 SHALL define a byte transfer as byte_valid=1 and byte_ready=1 on a rising edge.
REQ-014 SHALL use states IDLE, B1, B2, OPND and ISSUE; byte_ready=1 in all states except ISSUE.
REQ-015 SHALL accept opcode bytes MSB first: IDLE→B1→B2 on each transfer; the third transfer completes the 24-bit opcode.
REQ-016 SHALL decode opcodes LDA=24'h888800 (needs an operand byte, goes to OPND), INC=24'h888801 and DEC=24'h888802 (no operand, go to ISSUE, dec_data=8'h00).
REQ-017 SHALL treat any other opcode as illegal: dec_err=1 for exactly one cycle, return to IDLE, no issue.
REQ-018 SHALL move OPND→ISSUE on a transfer and capture byte_in into dec_data.
REQ-019 SHALL hold op_rdy=1 and acc_en=1, with opcode/dec_data stable, while in ISSUE; SHALL leave ISSUE for IDLE on the edge where acc_ready=1.
REQ-020 SHALL register all outputs: op_rdy rises on the cycle after the completing transfer (latency 1).
REQ-021 SHALL keep op_rdy=acc_en=0 outside ISSUE; opcode and dec_data keep their last issued values.
REQ-022 SHALL, in B1/B2/OPND, count consecutive cycles with no transfer (8-bit counter, cleared by each transfer and on entry to IDLE).
REQ-023 SHALL, when the count reaches TIMEOUT_CYCLES (nonzero), pulse dec_err, discard the partial instruction and return to IDLE.
REQ-024 SHALL give a transfer priority over a timeout that expires in the same cycle.
REQ-025 SHALL never time out in IDLE or ISSUE; ISSUE waits on acc_ready indefinitely.

Reset
REQ-026 SHALL, on dec_rst_n=0, go to IDLE immediately, discard any partial or pending instruction and clear all counters.
REQ-027 SHALL hold these output values during reset: byte_ready=0, opcode=24'h0, op_rdy=0, acc_en=0, dec_data=8'h0, dec_err=0.
REQ-028 SHALL drive byte_ready=1 from the first rising edge after release.

Configuration
REQ-029 SHALL, with DEC_ERR_CNT_EN defined, add output err_cnt (8 bits, reset 0) that increments on each dec_err pulse and saturates at 8'hFF.
REQ-030 SHALL, without DEC_ERR_CNT_EN, omit err_cnt and its counter; all other behaviour is identical.

Verification
REQ-031 SHALL test LDA: bytes 88,88,00,5A back-to-back with acc_ready=1 → one-cycle op_rdy=acc_en=1, opcode=888800, dec_data=5A, one cycle after the 5A transfer.
REQ-032 SHALL test backpressure: INC (88,88,01) with acc_ready=0 for 4 cycles → op_rdy held 5 cycles, byte_ready=0 throughout, dec_data=00.
REQ-033 SHALL test an illegal opcode: bytes 88,88,07 → single dec_err pulse, no op_rdy, next LDA decodes correctly; err_cnt=1 with DEC_ERR_CNT_EN.
REQ-034 SHALL test timeout: TIMEOUT_CYCLES=4, bytes 88,88 then idle → dec_err on the 4th idle cycle, state IDLE, following DEC decodes correctly.
REQ-035 SHALL test reset mid-instruction: dec_rst_n low after the 2nd byte of LDA → outputs zero immediately; after release, a full DEC issues with opcode=888802.
REQ-036 SHALL test the timeout/transfer collision: byte transfer on the cycle the count would expire → byte accepted, no dec_err.
